// File: rtl/paula_audio_mixer.sv
// Paula four-channel audio mixer: captured samples become 15-bit left/right mixes,
// each feeding a first-order sigma-delta bitstream. Macro PAULA_LED_FILTER_EN adds the LED low-pass filter.
module paula_audio_mixer #(
  parameter int FILTER_SHIFT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic        cck,
  input  logic [7:0]  sample0,
  input  logic [7:0]  sample1,
  input  logic [7:0]  sample2,
  input  logic [7:0]  sample3,
  input  logic        led,
  output logic [14:0] ldata,
  output logic [14:0] rdata,
  output logic        left,
  output logic        right
);

  logic [7:0]  hold0_q, hold1_q, hold2_q, hold3_q;
  logic [7:0]  hold0_d, hold1_d, hold2_d, hold3_d;
  logic [8:0]  lsum_q, rsum_q, lsum_d, rsum_d;
  logic [14:0] lmix_q, rmix_q, lmix_d, rmix_d;
  logic [14:0] ly_q, ry_q, ly_d, ry_d;
  logic [15:0] lacc_q, racc_q, lacc_d, racc_d;
  logic [14:0] lu, ru;

  always_comb begin
    hold0_d = hold0_q;
    hold1_d = hold1_q;
    hold2_d = hold2_q;
    hold3_d = hold3_q;
    if (clk7_en && cck) begin
      hold0_d = sample0;
      hold1_d = sample1;
      hold2_d = sample2;
      hold3_d = sample3;
    end
  end

  // Sum and mix stages read the pre-edge holding/sum values, so a capture on the
  // same edge only shows up one stage later.
  always_comb begin
    lsum_d = lsum_q;
    rsum_d = rsum_q;
    lmix_d = lmix_q;
    rmix_d = rmix_q;
    if (clk7_en) begin
      lsum_d = {hold1_q[7], hold1_q} + {hold2_q[7], hold2_q};
      rsum_d = {hold0_q[7], hold0_q} + {hold3_q[7], hold3_q};
      lmix_d = {lsum_q, 6'b0};
      rmix_d = {rsum_q, 6'b0};
    end
  end

`ifdef PAULA_LED_FILTER_EN
  logic signed [15:0] ldiff, rdiff, lstep, rstep, lnext, rnext;
  logic [1:0]         unused_carry;

  assign ldiff = $signed({lmix_q[14], lmix_q}) - $signed({ly_q[14], ly_q});
  assign rdiff = $signed({rmix_q[14], rmix_q}) - $signed({ry_q[14], ry_q});
  assign lstep = ldiff >>> FILTER_SHIFT;
  assign rstep = rdiff >>> FILTER_SHIFT;
  // y always lies between its old value and x, so bit 15 never carries information.
  assign lnext = $signed({ly_q[14], ly_q}) + lstep;
  assign rnext = $signed({ry_q[14], ry_q}) + rstep;
  assign unused_carry = {lnext[15], rnext[15]};

  always_comb begin
    ly_d = ly_q;
    ry_d = ry_q;
    if (clk7_en) begin
      ly_d = led ? lnext[14:0] : lmix_q;
      ry_d = led ? rnext[14:0] : rmix_q;
    end
  end
`else
  logic              unused_led;
  localparam int     unused_shift = FILTER_SHIFT;

  assign unused_led = led;

  always_comb begin
    ly_d = ly_q;
    ry_d = ry_q;
    if (clk7_en) begin
      ly_d = lmix_q;
      ry_d = rmix_q;
    end
  end
`endif

  // Offset-binary conversion: -16384 maps to 0, +16383 to 32767.
  assign lu = {~ly_q[14], ly_q[13:0]};
  assign ru = {~ry_q[14], ry_q[13:0]};

  always_comb begin
    lacc_d = {1'b0, lacc_q[14:0]} + {1'b0, lu};
    racc_d = {1'b0, racc_q[14:0]} + {1'b0, ru};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold0_q <= '0;
      hold1_q <= '0;
      hold2_q <= '0;
      hold3_q <= '0;
      lsum_q  <= '0;
      rsum_q  <= '0;
      lmix_q  <= '0;
      rmix_q  <= '0;
      ly_q    <= '0;
      ry_q    <= '0;
      lacc_q  <= '0;
      racc_q  <= '0;
    end else begin
      hold0_q <= hold0_d;
      hold1_q <= hold1_d;
      hold2_q <= hold2_d;
      hold3_q <= hold3_d;
      lsum_q  <= lsum_d;
      rsum_q  <= rsum_d;
      lmix_q  <= lmix_d;
      rmix_q  <= rmix_d;
      ly_q    <= ly_d;
      ry_q    <= ry_d;
      lacc_q  <= lacc_d;
      racc_q  <= racc_d;
    end
  end

  assign ldata = ly_q;
  assign rdata = ry_q;
  assign left  = lacc_q[15];
  assign right = racc_q[15];

endmodule
